// File: rtl/seg_display_capture.sv
// Receive-side monitor for a multiplexed 7-segment bus: waits for each scanned digit to settle,
// decodes the cathode pattern back to a nibble and publishes a complete frame of digits.
module seg_display_capture #(
    parameter int NUM_SEGMENTS   = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SEGMENTS-1:0]     anode,
    input  logic [7:0]                  cathode,
    output logic [4*NUM_SEGMENTS-1:0]   digit_val,
    output logic [NUM_SEGMENTS-1:0]     digit_dp,
    output logic [NUM_SEGMENTS-1:0]     digit_blank,
    output logic [NUM_SEGMENTS-1:0]     digit_bad,
    output logic                        frame_valid,
    output logic                        frame_err,
    output logic                        timeout
);

    localparam int STAB_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STAB_W-1:0]       STAB_MAX = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [STAB_W-1:0]       STAB_ONE = STAB_W'(1);
    localparam logic [TMO_W-1:0]        TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]        TMO_ONE  = TMO_W'(1);
    localparam logic [NUM_SEGMENTS-1:0] SEG_ONE  = NUM_SEGMENTS'(1);

    typedef enum logic {S_SETTLE, S_HELD} state_t;

    // Returns {bad, blank, nibble} for an active-low g..a segment pattern.
    function automatic logic [5:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   seg_decode = 6'h00;
            7'h79:   seg_decode = 6'h01;
            7'h24:   seg_decode = 6'h02;
            7'h30:   seg_decode = 6'h03;
            7'h19:   seg_decode = 6'h04;
            7'h12:   seg_decode = 6'h05;
            7'h02:   seg_decode = 6'h06;
            7'h78:   seg_decode = 6'h07;
            7'h00:   seg_decode = 6'h08;
            7'h10:   seg_decode = 6'h09;
            7'h08:   seg_decode = 6'h0A;
            7'h03:   seg_decode = 6'h0B;
            7'h46:   seg_decode = 6'h0C;
            7'h21:   seg_decode = 6'h0D;
            7'h06:   seg_decode = 6'h0E;
            7'h0E:   seg_decode = 6'h0F;
            7'h7F:   seg_decode = 6'h10;
            default: seg_decode = 6'h20;
        endcase
    endfunction

    logic [NUM_SEGMENTS-1:0]   anode_p0, anode_p1;
    logic [7:0]                cathode_p0, cathode_p1;
    logic [STAB_W-1:0]         stab_cnt;
    logic [TMO_W-1:0]          tmo_cnt;
    state_t                    state, state_nxt;
    logic                      changed, settled, do_eval, cap, multi_low, frame_rdy;
    logic [NUM_SEGMENTS-1:0]   low, seen;
    logic [5:0]                dec;
    logic [4*NUM_SEGMENTS-1:0] sh_val;
    logic [NUM_SEGMENTS-1:0]   sh_dp, sh_blank, sh_bad;

    // Stage p0: bus sampled; stage p1: previous sample for the stability compare
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_p0   <= '1;
            cathode_p0 <= '1;
            anode_p1   <= '1;
            cathode_p1 <= '1;
        end else begin
            anode_p0   <= anode;
            cathode_p0 <= cathode;
            anode_p1   <= anode_p0;
            cathode_p1 <= cathode_p0;
        end
    end

    assign changed   = (anode_p0 != anode_p1) || (cathode_p0 != cathode_p1);
    assign settled   = !changed && (stab_cnt == STAB_MAX);
    assign low       = ~anode_p0;
    assign multi_low = |(low & (low - SEG_ONE));
    assign dec       = seg_decode(cathode_p0[6:0]);
    assign frame_rdy = &seen;

    always_ff @(posedge clk) begin
        if (rst)
            stab_cnt <= '0;
        else if (changed)
            stab_cnt <= '0;
        else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + STAB_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_SETTLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SETTLE: if (settled) state_nxt = S_HELD;
            S_HELD:   if (changed) state_nxt = S_SETTLE;
            default:  state_nxt = S_SETTLE;
        endcase
    end

    // A settled sample is evaluated exactly once; blanking gaps (no anode low) fall through.
    always_comb begin
        do_eval = (state == S_SETTLE) && settled;
        cap     = do_eval && (low != '0) && !multi_low;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_bad   <= '0;
        end else if (cap) begin
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                if (low[i]) begin
                    sh_val[4*i +: 4] <= dec[3:0];
                    sh_dp[i]         <= ~cathode_p0[7];
                    sh_blank[i]      <= dec[4];
                    sh_bad[i]        <= dec[5];
                end
            end
        end
    end

    // Frame publish takes priority; a capture always beats an expiring timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen        <= '0;
            tmo_cnt     <= '0;
            digit_val   <= '0;
            digit_dp    <= '0;
            digit_blank <= '0;
            digit_bad   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            frame_valid <= frame_rdy;
            frame_err   <= do_eval && multi_low;
            timeout     <= 1'b0;
            if (frame_rdy) begin
                seen        <= '0;
                tmo_cnt     <= '0;
                digit_val   <= sh_val;
                digit_dp    <= sh_dp;
                digit_blank <= sh_blank;
                digit_bad   <= sh_bad;
            end else if (cap) begin
                seen    <= seen | low;
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_MAX) begin
                if (seen != '0) begin
                    seen    <= '0;
                    timeout <= 1'b1;
                    tmo_cnt <= '0;
                end
            end else begin
                tmo_cnt <= tmo_cnt + TMO_ONE;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed bench for seg_display_capture: scans digit patterns onto the bus and checks the
// published frames, error/timeout pulses and reset behaviour against hand-computed values.
module tb_seg_display_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic [15:0] digit_val;
    logic [3:0]  digit_dp, digit_blank, digit_bad;
    logic        frame_valid, frame_err, timeout;

    int total = 0;
    int bad   = 0;
    int fv_n  = 0, err_n = 0, tmo_n = 0;
    int fv0   = 0, err0  = 0, tmo0  = 0;

    seg_display_capture #(
        .NUM_SEGMENTS  (4),
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .anode      (anode),
        .cathode    (cathode),
        .digit_val  (digit_val),
        .digit_dp   (digit_dp),
        .digit_blank(digit_blank),
        .digit_bad  (digit_bad),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Pulse cycle counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) fv_n++;
        if (frame_err)   err_n++;
        if (timeout)     tmo_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [7:0] c, input int n);
        anode   = a;
        cathode = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        fv0  = fv_n;
        err0 = err_n;
        tmo0 = tmo_n;
    endtask

    initial begin
        rst     = 1'b1;
        anode   = 4'hF;
        cathode = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        check("reset_val",    {16'h0, digit_val}, 32'h0);
        check("reset_flags",  {20'h0, digit_dp, digit_blank, digit_bad}, 32'h0);
        check("reset_pulses", {29'h0, frame_valid, frame_err, timeout}, 32'h0);
        rst = 1'b0;
        show(4'hF, 8'hFF, 20);

        // Test 1: digits 1,2,3,4 with exact publish latency
        mark();
        show(4'hE, 8'hF9, 100);
        show(4'hD, 8'hA4, 100);
        show(4'hB, 8'hB0, 100);
        show(4'h7, 8'h99, 18);
        check("t1_fv_before", {31'h0, frame_valid}, 32'h0);
        show(4'h7, 8'h99, 1);
        check("t1_fv_at", {31'h0, frame_valid}, 32'h1);
        check("t1_val", {16'h0, digit_val}, 32'h4321);
        show(4'h7, 8'h99, 1);
        check("t1_fv_after", {31'h0, frame_valid}, 32'h0);
        show(4'h7, 8'h99, 79);
        show(4'hF, 8'hFF, 30);
        check("t1_fv_count", fv_n - fv0, 1);
        check("t1_flags", {20'h0, digit_dp, digit_blank, digit_bad}, 32'h0);
        check("t1_err_tmo", (err_n - err0) + (tmo_n - tmo0), 0);

        // Test 2: digit 0 toggling faster than the settle time is never captured
        mark();
        for (int i = 0; i < 6; i++) begin
            show(4'hE, 8'hF9, 8);
            show(4'hE, 8'hA4, 8);
        end
        show(4'hD, 8'hF8, 100);
        show(4'hB, 8'h80, 100);
        show(4'h7, 8'h90, 100);
        check("t2_no_frame", fv_n - fv0, 0);
        show(4'hE, 8'h92, 100);
        show(4'hF, 8'hFF, 30);
        check("t2_frame", fv_n - fv0, 1);
        check("t2_val", {16'h0, digit_val}, 32'h9875);

        // Test 3: two anodes low -> one error pulse, no shadow written
        mark();
        show(4'hE, 8'h88, 100);
        show(4'hD, 8'h83, 100);
        show(4'hB, 8'hC6, 100);
        show(4'hC, 8'h86, 50);
        check("t3_err_once", err_n - err0, 1);
        check("t3_no_frame", fv_n - fv0, 0);
        show(4'h7, 8'hA1, 100);
        show(4'hF, 8'hFF, 30);
        check("t3_frame", fv_n - fv0, 1);
        check("t3_val", {16'h0, digit_val}, 32'hDCBA);

        // Test 4: blank with DP on digit 2, undecodable pattern with DP on digit 3
        mark();
        show(4'hE, 8'hC0, 100);
        show(4'hD, 8'h8E, 100);
        show(4'hB, 8'h7F, 100);
        show(4'h7, 8'h55, 100);
        show(4'hF, 8'hFF, 30);
        check("t4_frame", fv_n - fv0, 1);
        check("t4_val",   {16'h0, digit_val}, 32'h00F0);
        check("t4_dp",    {28'h0, digit_dp}, 32'hC);
        check("t4_blank", {28'h0, digit_blank}, 32'h4);
        check("t4_bad",   {28'h0, digit_bad}, 32'h8);

        // Test 5: partial frame timeout, then stale digits must not complete a frame
        mark();
        show(4'hE, 8'hF9, 100);
        show(4'hD, 8'hA4, 100);
        show(4'hF, 8'hFF, 100);
        check("t5_no_early_tmo", tmo_n - tmo0, 0);
        show(4'hF, 8'hFF, 40);
        check("t5_tmo", tmo_n - tmo0, 1);
        show(4'hB, 8'h80, 100);
        show(4'h7, 8'h90, 100);
        show(4'hF, 8'hFF, 30);
        check("t5_no_stale_frame", fv_n - fv0, 0);
        show(4'hE, 8'h82, 100);
        show(4'hD, 8'hF8, 100);
        show(4'hF, 8'hFF, 30);
        check("t5_frame", fv_n - fv0, 1);
        check("t5_val", {16'h0, digit_val}, 32'h9876);

        // Test 6: reset after three digits discards the partial frame
        mark();
        show(4'hE, 8'hF9, 100);
        show(4'hD, 8'hA4, 100);
        show(4'hB, 8'hB0, 100);
        rst = 1'b1;
        show(4'hF, 8'hFF, 2);
        check("t6_rst_val",   {16'h0, digit_val}, 32'h0);
        check("t6_rst_flags", {20'h0, digit_dp, digit_blank, digit_bad}, 32'h0);
        rst = 1'b0;
        show(4'hF, 8'hFF, 20);
        show(4'h7, 8'h99, 100);
        show(4'hE, 8'hF9, 100);
        show(4'hD, 8'hA4, 100);
        check("t6_no_frame", fv_n - fv0, 0);
        show(4'hB, 8'hB0, 100);
        show(4'hF, 8'hFF, 30);
        check("t6_frame", fv_n - fv0, 1);
        check("t6_val", {16'h0, digit_val}, 32'h4321);
        check("t6_no_pulses", (err_n - err0) + (tmo_n - tmo0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
